// File: rtl/conv_frame_controller_if.sv
// Bundled control/handshake signals between the KxK convolution frame controller
// and its surrounding datapath, image/result memories and stream endpoints.
interface conv_frame_controller_if #(
  parameter int ADDR_W = 8,
  parameter int TAP_W  = 4
);
  logic              start_i;
  logic              bypass_i;
  logic              abort_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              img_wr_o;
  logic [ADDR_W-1:0] img_addr_o;
  logic              acc_clear_o;
  logic              acc_en_o;
  logic [TAP_W-1:0]  tap_idx_o;
  logic              res_wr_o;
  logic [ADDR_W-1:0] res_addr_o;
  logic              out_sel_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              out_last_o;
  logic              busy_o;
  logic              done_o;

  // Environment side: drives requests and stream handshakes into the controller
  modport master (
    output start_i, bypass_i, abort_i, in_valid_i, out_ready_i,
    input  in_ready_o, img_wr_o, img_addr_o, acc_clear_o, acc_en_o, tap_idx_o,
           res_wr_o, res_addr_o, out_sel_o, out_valid_o, out_last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, bypass_i, abort_i, in_valid_i, out_ready_i,
    output in_ready_o, img_wr_o, img_addr_o, acc_clear_o, acc_en_o, tap_idx_o,
           res_wr_o, res_addr_o, out_sel_o, out_valid_o, out_last_o, busy_o, done_o
  );
endinterface

// File: rtl/conv_frame_controller.sv
// Frame sequencer for the streaming KxK convolution engine: loads a frame, walks
// kernel taps over every valid window, writes results, then streams them out.
module conv_frame_controller #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 6,
  parameter int K      = 3,
  parameter int ADDR_W = 8,
  parameter int TAP_W  = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  conv_frame_controller_if.slave bus
);
  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;

  localparam logic [ADDR_W-1:0] NPIX_M1 = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] NWIN_M1 = ADDR_W'(OW * OH - 1);
  localparam logic [ADDR_W-1:0] OW_M1   = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OH_M1   = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [TAP_W-1:0]  K_M1    = TAP_W'(K - 1);
  localparam logic [TAP_W-1:0]  TAPS_M1 = TAP_W'(K * K - 1);
  localparam logic [TAP_W-1:0]  T_ONE   = TAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_WRITE,
    S_OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic              start_q, bypass_q, done_q;
  logic [ADDR_W-1:0] pix_q, out_idx_q, wr_q, wc_q;
  logic [TAP_W-1:0]  t_q, tr_q, tc_q;

  logic              start_acc, in_fire, out_fire;
  logic              last_tap, last_col, last_win, out_last;
  logic [ADDR_W-1:0] nout_m1;

  assign start_acc = bus.start_i && !start_q && (state_q == S_IDLE);
  assign in_fire   = (state_q == S_LOAD) && bus.in_valid_i;
  assign out_fire  = (state_q == S_OUTPUT) && bus.out_ready_i;
  assign last_tap  = (t_q == TAPS_M1);
  assign last_col  = (wc_q == OW_M1);
  assign last_win  = (wr_q == OH_M1) && last_col;
  assign nout_m1   = bypass_q ? NPIX_M1 : NWIN_M1;
  assign out_last  = (out_idx_q == nout_m1);

  // Abort beats the normal flow in every active state; it is ignored in IDLE
  always_comb begin
    state_d = state_q;
    if (bus.abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_acc) state_d = S_LOAD;
        S_LOAD:   if (in_fire && (pix_q == NPIX_M1)) state_d = bypass_q ? S_OUTPUT : S_CALC;
        S_CALC:   if (last_tap) state_d = S_WRITE;
        S_WRITE:  state_d = last_win ? S_OUTPUT : S_CALC;
        S_OUTPUT: if (out_fire && out_last) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.img_wr_o    = 1'b0;
    bus.img_addr_o  = '0;
    bus.acc_clear_o = 1'b0;
    bus.acc_en_o    = 1'b0;
    bus.tap_idx_o   = '0;
    bus.res_wr_o    = 1'b0;
    bus.res_addr_o  = '0;
    bus.out_sel_o   = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.out_last_o  = 1'b0;
    bus.busy_o      = (state_q != S_IDLE);
    bus.done_o      = done_q;
    case (state_q)
      S_LOAD: begin
        bus.in_ready_o = 1'b1;
        bus.img_wr_o   = bus.in_valid_i;
        bus.img_addr_o = pix_q;
      end
      S_CALC: begin
        bus.acc_en_o    = 1'b1;
        bus.acc_clear_o = (t_q == '0);
        bus.tap_idx_o   = t_q;
        bus.img_addr_o  = (wr_q + ADDR_W'(tr_q)) * IMG_W_A + wc_q + ADDR_W'(tc_q);
      end
      S_WRITE: begin
        bus.res_wr_o   = 1'b1;
        bus.res_addr_o = wr_q * OW_A + wc_q;
      end
      // Both buffers are async-read, so the index is presented directly
      S_OUTPUT: begin
        bus.out_valid_o = 1'b1;
        bus.out_sel_o   = bypass_q;
        bus.out_last_o  = out_last;
        if (bypass_q) bus.img_addr_o = out_idx_q;
        else          bus.res_addr_o = out_idx_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      bypass_q  <= 1'b0;
      done_q    <= 1'b0;
      pix_q     <= '0;
      out_idx_q <= '0;
      wr_q      <= '0;
      wc_q      <= '0;
      t_q       <= '0;
      tr_q      <= '0;
      tc_q      <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start_i;
      done_q  <= 1'b0;
      if ((bus.abort_i && (state_q != S_IDLE)) || start_acc) begin
        if (start_acc) bypass_q <= bus.bypass_i;
        pix_q     <= '0;
        out_idx_q <= '0;
        wr_q      <= '0;
        wc_q      <= '0;
        t_q       <= '0;
        tr_q      <= '0;
        tc_q      <= '0;
      end else begin
        case (state_q)
          S_LOAD: if (in_fire) pix_q <= pix_q + A_ONE;
          // Tap row/col counters track t so no divider is needed for t/K, t%K
          S_CALC: begin
            if (last_tap) begin
              t_q  <= '0;
              tr_q <= '0;
              tc_q <= '0;
            end else begin
              t_q <= t_q + T_ONE;
              if (tc_q == K_M1) begin
                tc_q <= '0;
                tr_q <= tr_q + T_ONE;
              end else begin
                tc_q <= tc_q + T_ONE;
              end
            end
          end
          S_WRITE: begin
            if (last_win) begin
              wr_q      <= '0;
              wc_q      <= '0;
              out_idx_q <= '0;
            end else if (last_col) begin
              wc_q <= '0;
              wr_q <= wr_q + A_ONE;
            end else begin
              wc_q <= wc_q + A_ONE;
            end
          end
          S_OUTPUT: begin
            if (out_fire) begin
              if (out_last) begin
                out_idx_q <= '0;
                done_q    <= 1'b1;
              end else begin
                out_idx_q <= out_idx_q + A_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
